// File: rtl/seg_scan_ctrl.sv
// Scan controller for N_DIG common-anode digits sharing one hex decoder.
// Optional leading-zero blanking: define SEG_LZB_EN.
module seg_scan_ctrl #(
  parameter int N_DIG = 4,
  parameter int DWELL = 50000,
  parameter int GUARD = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [4*N_DIG-1:0] digits_in,
  input  logic [N_DIG-1:0]   en_in,
  output logic [3:0]         cif_hexa,
  output logic [N_DIG-1:0]   an_n,
  output logic               load_ack,
  output logic               frame_tick
);

  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  typedef enum logic {
    ST_GUARD,
    ST_SHOW
  } state_t;

  state_t             state, state_d;
  logic [IW-1:0]      idx, idx_d, idx_nx;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [4*N_DIG-1:0] act_dig, act_dig_d;
  logic [N_DIG-1:0]   act_en, act_en_d;
  logic [4*N_DIG-1:0] sh_dig, sh_dig_d;
  logic [N_DIG-1:0]   sh_en, sh_en_d;
  logic               pend, pend_d;
  logic [4*N_DIG-1:0] src_dig;
  logic [N_DIG-1:0]   src_en;
  logic [3:0]         hex_d;
  logic [N_DIG-1:0]   an_d;
  logic               ack_d, tick_d;

`ifdef SEG_LZB_EN
  function automatic logic [N_DIG-1:0] lzb_mask(
    input logic [4*N_DIG-1:0] d
  );
    logic [N_DIG-1:0] m;
    logic             lead;
    m    = '1;
    lead = 1'b1;
    for (int i = N_DIG - 1; i >= 1; i--) begin
      if (lead && d[4*i +: 4] == 4'h0) m[i] = 1'b0;
      else lead = 1'b0;
    end
    return m;
  endfunction
`endif

  // Next-state, image apply and registered-output values
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cnt_d     = cnt + 1'b1;
    act_dig_d = act_dig;
    act_en_d  = act_en;
    sh_dig_d  = sh_dig;
    sh_en_d   = sh_en;
    pend_d    = pend;
    hex_d     = cif_hexa;
    an_d      = an_n;
    ack_d     = 1'b0;
    tick_d    = 1'b0;
    idx_nx    = (idx == IW'(N_DIG - 1)) ? '0 : idx + 1'b1;
    src_dig   = load ? digits_in : sh_dig;
    src_en    = load ? en_in : sh_en;

    if (load) begin
      sh_dig_d = digits_in;
      sh_en_d  = en_in;
      pend_d   = 1'b1;
    end

    unique case (state)
      ST_GUARD: begin
        an_d = '1;
        if (cnt == CNT_W'(GUARD - 1)) begin
          cnt_d   = '0;
          state_d = ST_SHOW;
          idx_d   = idx_nx;
          if (idx_nx == '0) begin
            tick_d = 1'b1;
            if (load || pend) begin
              act_dig_d = src_dig;
`ifdef SEG_LZB_EN
              act_en_d  = src_en & lzb_mask(src_dig);
`else
              act_en_d  = src_en;
`endif
              ack_d     = 1'b1;
              pend_d    = 1'b0;
            end
          end
          for (int i = 0; i < N_DIG; i++) begin
            if (idx_nx == IW'(i)) begin
              hex_d   = act_dig_d[4*i +: 4];
              an_d[i] = ~act_en_d[i];
            end
          end
        end
      end
      ST_SHOW: begin
        if (cnt == CNT_W'(DWELL - 1)) begin
          cnt_d   = '0;
          state_d = ST_GUARD;
          an_d    = '1;
        end
      end
      default: state_d = ST_GUARD;
    endcase
  end

  // State, image and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_GUARD;
      idx        <= IW'(N_DIG - 1);
      cnt        <= '0;
      act_dig    <= '0;
      act_en     <= '0;
      sh_dig     <= '0;
      sh_en      <= '0;
      pend       <= 1'b0;
      cif_hexa   <= 4'h0;
      an_n       <= '1;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      act_dig    <= act_dig_d;
      act_en     <= act_en_d;
      sh_dig     <= sh_dig_d;
      sh_en      <= sh_en_d;
      pend       <= pend_d;
      cif_hexa   <= hex_d;
      an_n       <= an_d;
      load_ack   <= ack_d;
      frame_tick <= tick_d;
    end
  end

endmodule
